// File: rtl/dds_phase_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dds_phase_pkg
// Description : Shared types and constants for the DDS phase engine.
// Revision    : 1.0 - initial release
// ============================================================================
package dds_phase_pkg;

    // Profile update mode carried on cfg_mode
    typedef enum logic {
        MODE_COHERENT   = 1'b0,
        MODE_CONTINUOUS = 1'b1
    } cfg_mode_e;

    // Partial-product slice width (17x17 unsigned DSP slices)
    localparam int PP_W = 17;

    // Acceptance-to-output latency: subtract stage + multiplier + final add
    function automatic int dds_lat(input int mul_stages);
        return mul_stages + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dds_pp_mul.sv
`default_nettype none
// ============================================================================
// Module      : dds_pp_mul
// Description : Pipelined unsigned multiplier built from PP_W x PP_W slices.
//               Returns only product bits [PH_W+FRAC_SHIFT-1:FRAC_SHIFT];
//               slices lying wholly above that range are never built.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_pp_mul
    import dds_phase_pkg::*;
#(
    parameter int TIME_W     = 48,
    parameter int FREQ_W     = 48,
    parameter int PH_W       = 48,
    parameter int FRAC_SHIFT = 4,
    parameter int MUL_STAGES = 3
) (
    input  logic              clk,
    input  logic [TIME_W-1:0] i_a,
    input  logic [FREQ_W-1:0] i_b,
    output logic [PH_W-1:0]   o_p
);

    localparam int c_KEEP_W = PH_W + FRAC_SHIFT;
    localparam int c_NA     = (TIME_W + PP_W - 1) / PP_W;
    localparam int c_NB     = (FREQ_W + PP_W - 1) / PP_W;
    localparam int c_AW     = c_NA * PP_W;
    localparam int c_BW     = c_NB * PP_W;

    logic [c_AW-1:0]     w_a_ext;
    logic [c_BW-1:0]     w_b_ext;
    logic [c_KEEP_W-1:0] w_term [c_NA*c_NB];
    logic [c_KEEP_W-1:0] w_total;
    logic [PH_W-1:0]     r_sum;
    logic                w_unused_lsb;

    assign w_a_ext = c_AW'(i_a);
    assign w_b_ext = c_BW'(i_b);

    // Stage 1: register each needed partial product, trimmed to the bits
    // that can still reach the kept range.
    for (genvar gi = 0; gi < c_NA; gi++) begin : g_a
        for (genvar gj = 0; gj < c_NB; gj++) begin : g_b
            localparam int c_SH = PP_W * (gi + gj);
            if (c_SH < c_KEEP_W) begin : g_keep
                localparam int c_PW = ((c_KEEP_W - c_SH) < 2 * PP_W) ?
                                      (c_KEEP_W - c_SH) : 2 * PP_W;
                logic [c_PW-1:0] r_pp;
                // Slice product, truncated modulo 2^c_PW
                always_ff @(posedge clk) begin
                    r_pp <= c_PW'(w_a_ext[gi*PP_W +: PP_W]) *
                            c_PW'(w_b_ext[gj*PP_W +: PP_W]);
                end
                assign w_term[gi*c_NB+gj] = c_KEEP_W'(r_pp) << c_SH;
            end else begin : g_skip
                assign w_term[gi*c_NB+gj] = '0;
            end
        end
    end

    // Sum of aligned partial products, modulo 2^(PH_W+FRAC_SHIFT)
    always_comb begin
        w_total = '0;
        for (int k = 0; k < c_NA * c_NB; k++) begin
            w_total = w_total + w_term[k];
        end
    end

    // The discarded fraction bits only matter as carries into the kept range
    assign w_unused_lsb = ^w_total[FRAC_SHIFT-1:0];

    // Stage 2: register the kept product window
    always_ff @(posedge clk) begin
        r_sum <= w_total[c_KEEP_W-1:FRAC_SHIFT];
    end

    if (MUL_STAGES > 2) begin : g_dly
        logic [PH_W-1:0] r_dly [MUL_STAGES-2];
        // Remaining stages are plain retiming registers
        always_ff @(posedge clk) begin
            r_dly[0] <= r_sum;
            for (int k = 1; k < MUL_STAGES - 2; k++) begin
                r_dly[k] <= r_dly[k-1];
            end
        end
        assign o_p = r_dly[MUL_STAGES-3];
    end else begin : g_nodly
        assign o_p = r_sum;
    end

endmodule
`default_nettype wire

// File: rtl/dds_phase_engine.sv
`default_nettype none
// ============================================================================
// Module      : dds_phase_engine
// Description : Timestamp-to-phase engine with coherent and phase-continuous
//               profile updates. out_phase = E + ((t-A)*B >> FRAC_SHIFT)
//               + (C aligned to MSBs), modulo 2^PH_W.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_phase_engine
    import dds_phase_pkg::*;
#(
    parameter int TIME_W     = 48,
    parameter int FREQ_W     = 48,
    parameter int POFF_W     = 14,
    parameter int PH_W       = 48,
    parameter int FRAC_SHIFT = 4,
    parameter int MUL_STAGES = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TIME_W-1:0] in_time,
    output logic              out_valid,
    output logic [PH_W-1:0]   out_phase,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              cfg_mode,
    input  logic [TIME_W-1:0] cfg_offset,
    input  logic [TIME_W-1:0] cfg_time,
    input  logic [FREQ_W-1:0] cfg_freq,
    input  logic [POFF_W-1:0] cfg_phase,
    output logic              busy
);

    localparam int c_LAT   = dds_lat(MUL_STAGES);
    localparam int c_CNT_W = $clog2(c_LAT + 1);
    localparam int c_CSH   = PH_W - POFF_W;

    // Profile and pending continuous-update values
    logic [TIME_W-1:0]  r_a;
    logic [FREQ_W-1:0]  r_b;
    logic [POFF_W-1:0]  r_c;
    logic [PH_W-1:0]    r_e;
    logic [TIME_W-1:0]  r_pend_time;
    logic [FREQ_W-1:0]  r_pend_freq;
    logic [POFF_W-1:0]  r_pend_phase;
    logic [c_CNT_W-1:0] r_cnt;

    // Pipeline
    logic [TIME_W-1:0]  r_diff;
    logic [FREQ_W-1:0]  r_s1_b;
    logic               r_v_p [MUL_STAGES+1];
    logic               r_t_p [MUL_STAGES+1];
    logic [POFF_W-1:0]  r_c_p [MUL_STAGES+1];
    logic [PH_W-1:0]    r_e_p [MUL_STAGES+1];
    logic [PH_W-1:0]    w_term;
    logic [PH_W-1:0]    w_fin;
    logic               r_fin_tok;
    logic [PH_W-1:0]    r_fin_e;

    logic w_idle, w_cfg_cont, w_tok, w_coh, w_acc, w_last_smp, w_last_tok;

    assign w_idle     = (r_cnt == '0);
    assign w_cfg_cont = cfg_valid && (cfg_mode_e'(cfg_mode) == MODE_CONTINUOUS);
    assign w_tok      = w_cfg_cont && w_idle;
    assign w_coh      = cfg_valid && w_idle && !w_cfg_cont;

    // A continuous request takes the pipeline slot, so it blocks samples
    // in its own acceptance cycle as well.
    assign in_ready  = w_idle && !w_cfg_cont;
    assign cfg_ready = w_idle;
    assign busy      = !w_idle || w_cfg_cont;
    assign w_acc     = in_valid && in_ready;

    // Busy counter: covers the token's trip through the pipeline
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (w_tok) begin
            r_cnt <= c_CNT_W'(c_LAT);
        end else if (!w_idle) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Subtract stage plus snapshot of B, C, E; sidebands ride along
    always_ff @(posedge clk) begin
        r_diff   <= (w_tok ? cfg_time : in_time) - r_a;
        r_s1_b   <= r_b;
        r_c_p[0] <= w_tok ? '0 : r_c;
        r_e_p[0] <= r_e;
        for (int i = 1; i <= MUL_STAGES; i++) begin
            r_c_p[i] <= r_c_p[i-1];
            r_e_p[i] <= r_e_p[i-1];
        end
    end

    // Valid/token shift registers, cleared on reset to drop in-flight work
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i <= MUL_STAGES; i++) begin
                r_v_p[i] <= 1'b0;
                r_t_p[i] <= 1'b0;
            end
        end else begin
            r_v_p[0] <= w_acc || w_tok;
            r_t_p[0] <= w_tok;
            for (int i = 1; i <= MUL_STAGES; i++) begin
                r_v_p[i] <= r_v_p[i-1];
                r_t_p[i] <= r_t_p[i-1];
            end
        end
    end

    dds_pp_mul #(
        .TIME_W     (TIME_W),
        .FREQ_W     (FREQ_W),
        .PH_W       (PH_W),
        .FRAC_SHIFT (FRAC_SHIFT),
        .MUL_STAGES (MUL_STAGES)
    ) u_mul (
        .clk (clk),
        .i_a (r_diff),
        .i_b (r_s1_b),
        .o_p (w_term)
    );

    // Tokens carry C = 0, so w_fin is E_old + term(cfg_time) for them
    assign w_fin      = r_e_p[MUL_STAGES] + w_term + (PH_W'(r_c_p[MUL_STAGES]) << c_CSH);
    assign w_last_smp = r_v_p[MUL_STAGES] && !r_t_p[MUL_STAGES];
    assign w_last_tok = r_v_p[MUL_STAGES] &&  r_t_p[MUL_STAGES];

    // Output stage; out_phase holds its last value between samples
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_phase <= '0;
            r_fin_tok <= 1'b0;
        end else begin
            out_valid <= w_last_smp;
            r_fin_tok <= w_last_tok;
            if (w_last_smp) begin
                out_phase <= w_fin;
            end
        end
    end

    // Rebased phase captured when the token leaves the pipeline
    always_ff @(posedge clk) begin
        if (w_last_tok) begin
            r_fin_e <= w_fin;
        end
    end

    // New continuous-mode profile waiting for its token to commit
    always_ff @(posedge clk) begin
        if (w_tok) begin
            r_pend_time  <= cfg_time;
            r_pend_freq  <= cfg_freq;
            r_pend_phase <= cfg_phase;
        end
    end

    // Profile registers: coherent replace or continuous commit
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
            r_e <= '0;
        end else if (r_fin_tok) begin
            r_a <= r_pend_time;
            r_b <= r_pend_freq;
            r_c <= r_pend_phase;
            r_e <= r_fin_e;
        end else if (w_coh) begin
            r_a <= cfg_offset;
            r_b <= cfg_freq;
            r_c <= cfg_phase;
            r_e <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dds_phase_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_phase_engine
// Description : Scoreboard testbench for dds_phase_engine (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_phase_engine;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_time;
    logic        out_valid;
    logic [47:0] out_phase;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_mode;
    logic [47:0] cfg_offset;
    logic [47:0] cfg_time;
    logic [47:0] cfg_freq;
    logic [13:0] cfg_phase;
    logic        busy;

    dds_phase_engine u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_time    (in_time),
        .out_valid  (out_valid),
        .out_phase  (out_phase),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mode   (cfg_mode),
        .cfg_offset (cfg_offset),
        .cfg_time   (cfg_time),
        .cfg_freq   (cfg_freq),
        .cfg_phase  (cfg_phase),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] ph;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   run_len  = 0;
    int   max_run  = 0;

    // Bench-side profile model
    logic [47:0] m_a, m_b, m_e;
    logic [13:0] m_c;
    int          m_busy;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [47:0] f_model(input logic [47:0] t, input logic [47:0] a,
                                            input logic [47:0] b, input logic [13:0] c,
                                            input logic [47:0] e);
        logic [47:0] d;
        logic [95:0] p;
        d = t - a;
        p = {48'd0, d} * {48'd0, b};
        return e + p[51:4] + {c, 34'd0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every out_valid must match the oldest expected entry
    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL spurious_out_valid: got out_valid=1 with phase 0x%0h, expected none", out_phase);
            end else begin
                e = q.pop_front();
                chk("out_phase", 64'(out_phase), 64'(e.ph));
                chk("latency", 64'(cyc - e.cyc), 64'(LAT));
            end
        end else begin
            run_len = 0;
        end
    end

    // One cycle of stimulus; called just after a rising edge
    task automatic step(input bit iv, input logic [47:0] t, input bit cv, input bit md,
                        input logic [47:0] off, input logic [47:0] ctm,
                        input logic [47:0] frq, input logic [13:0] ph,
                        input bit hx, input logic [47:0] hv,
                        output bit acc, output bit ir);
        bit   e_ir, e_cr, e_bz;
        exp_t x;
        in_valid   = iv;
        in_time    = t;
        cfg_valid  = cv;
        cfg_mode   = md;
        cfg_offset = off;
        cfg_time   = ctm;
        cfg_freq   = frq;
        cfg_phase  = ph;
        @(negedge clk);
        e_cr = (m_busy == 0);
        e_ir = e_cr && !(cv && md);
        e_bz = !e_cr || (cv && md);
        chk("in_ready", 64'(in_ready), 64'(e_ir));
        chk("cfg_ready", 64'(cfg_ready), 64'(e_cr));
        chk("busy", 64'(busy), 64'(e_bz));
        ir  = in_ready;
        acc = iv && e_ir;
        if (acc) begin
            x.ph  = hx ? hv : f_model(t, m_a, m_b, m_c, m_e);
            x.cyc = cyc;
            q.push_back(x);
        end
        if (cv && e_cr && !md) begin
            m_a = off; m_b = frq; m_c = ph; m_e = '0;
        end else if (cv && e_cr && md) begin
            m_e    = f_model(ctm, m_a, m_b, 14'd0, m_e);
            m_a    = ctm; m_b = frq; m_c = ph;
            m_busy = LAT;
        end else if (m_busy > 0) begin
            m_busy--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bit a, r;
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, '0, a, r);
    endtask

    task automatic samp(input logic [47:0] t, input logic [47:0] hv);
        bit a, r;
        step(1'b1, t, 1'b0, 1'b0, '0, '0, '0, '0, 1'b1, hv, a, r);
    endtask

    task automatic cfg_coh(input logic [47:0] off, input logic [47:0] frq, input logic [13:0] ph);
        bit a, r;
        step(1'b0, '0, 1'b1, 1'b0, off, '0, frq, ph, 1'b0, '0, a, r);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) idle();
        n_checks++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d outputs outstanding, expected 0", q.size());
        end
        idle();
        idle();
    endtask

    task automatic do_reset();
        resetn     = 1'b0;
        in_valid   = 1'b0;
        in_time    = '0;
        cfg_valid  = 1'b0;
        cfg_mode   = 1'b0;
        cfg_offset = '0;
        cfg_time   = '0;
        cfg_freq   = '0;
        cfg_phase  = '0;
        q.delete();
        m_a = '0; m_b = '0; m_c = '0; m_e = '0; m_busy = 0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_phase", 64'(out_phase), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        bit          a, r;
        int          ir_low;
        logic [47:0] rt;

        do_reset();

        // Coherent profile, basic timing
        cfg_coh(48'd0, 48'h10, 14'd0);
        samp(48'd100, 48'd100);
        drain();

        // Phase offset lands in the MSBs
        cfg_coh(48'd0, 48'h10, 14'd1);
        samp(48'd100, 48'h4_0000_0064);
        drain();

        // Negative difference wraps
        cfg_coh(48'd200, 48'h10, 14'd0);
        samp(48'd100, 48'hFFFF_FFFF_FF9C);
        drain();

        // Continuous update with a sample held pending across the window
        cfg_coh(48'd0, 48'h10, 14'd0);
        ir_low = 0;
        step(1'b1, 48'd1010, 1'b1, 1'b1, '0, 48'd1000, 48'h20, 14'd0, 1'b1, 48'd1020, a, r);
        if (!r) ir_low++;
        for (int i = 0; i < 20 && !a; i++) begin
            step(1'b1, 48'd1010, 1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 48'd1020, a, r);
            if (!r) ir_low++;
        end
        chk("in_ready_low_cycles", 64'(ir_low), 64'(LAT + 1));
        idle();
        drain();

        // Back-to-back random stream with a coherent update mid-stream
        max_run = 0;
        for (int i = 0; i < 64; i++) begin
            rt = 48'({$urandom(), $urandom()});
            if (i == 32)
                step(1'b1, rt, 1'b1, 1'b0, 48'({$urandom(), $urandom()}), '0,
                     48'({$urandom(), $urandom()}), 14'($urandom()), 1'b0, '0, a, r);
            else
                step(1'b1, rt, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, '0, a, r);
        end
        drain();
        chk("stream_no_gaps", 64'(max_run), 64'd64);

        // Reset during a continuous update: no output, no commit
        cfg_coh(48'd3, 48'h55, 14'd7);
        step(1'b0, '0, 1'b1, 1'b1, '0, 48'd777, 48'h1234, 14'd9, 1'b0, '0, a, r);
        idle();
        idle();
        do_reset();
        for (int i = 0; i < LAT + 3; i++) idle();
        samp(48'd500, 48'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
